// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache and dcache requests onto one single-port RAM, data side first.
// Latency: request seen in cycle 0, RAM driven from cycle 1, wait drops in the first ACCESS cycle (min 2).
// Backpressure: iwait/dwait stay high until the RAM reports ACCESS; the losing side waits in IDLE.
// Optional build macro MEM_ARBITER_RR_EN: alternate grants when both sides request in the same cycle.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction cache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data cache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // shared RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  // sticky abandoned-access flag
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  localparam logic [1:0]       RAM_ACCESS = 2'd2;
  // Counter value seen during the last permitted access cycle.
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             d_req;
  logic             ram_done;
  logic             cnt_hit;
  logic             req_held;
  logic             pick_data;
  logic             timeout_set;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == RAM_ACCESS);
  assign cnt_hit  = (cnt >= CNT_LAST);

  // The granted requester must still be asking; a dropped request aborts the grant.
  assign req_held = ((state == IACC) & iREN) | ((state == DACC) & d_req);

  // Abandon the access when the counter reaches its limit without the RAM completing.
  assign timeout_set = req_held & ~ram_done & cnt_hit;

`ifdef MEM_ARBITER_RR_EN
  // 0 = instruction side was granted last, 1 = data side was granted last.
  logic last_grant;

  // On contention, favour the side that did not win the previous grant.
  assign pick_data = d_req & (~iREN | ~last_grant);

  // Remember which side won each grant taken from IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant <= 1'b0;
    end else if ((state == IDLE) && (d_req || iREN)) begin
      last_grant <= pick_data;
    end
  end
`else
  // Fixed priority: any data request beats an instruction request.
  assign pick_data = d_req;
`endif

  // State register; reset drops any transaction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant only from IDLE; an access state is left on completion, abort or timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_data) begin
          next_state = DACC;
        end else if (iREN) begin
          next_state = IACC;
        end
      end
      IACC: begin
        if (!iREN || ram_done || cnt_hit) begin
          next_state = IDLE;
        end
      end
      DACC: begin
        if (!d_req || ram_done || cnt_hit) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Access-cycle counter: held at zero in IDLE, counts up and saturates inside an access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timeout <= 1'b0;
    end else if (timeout_set) begin
      timeout <= 1'b1;
    end
  end

  // RAM drive and requester responses follow the registered grant and the live request lines.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      IACC: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (iREN && ram_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // A simultaneous read and write is treated as the write.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (d_req && ram_done) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random icache/dcache traffic against a RAM model.
// Expected data comes from a word-array memory model updated on each completed write.
// Build with MEM_ARBITER_RR_EN defined to exercise the alternating-grant variant.
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic        timeout;

  int nchk = 0;
  int nerr = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
  );

  initial begin
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, ".ramREN"}, ramREN, 1'b0);
    chk1({tag, ".ramWEN"}, ramWEN, 1'b0);
    chk1({tag, ".iwait"}, iwait, 1'b1);
    chk1({tag, ".dwait"}, dwait, 1'b1);
  endtask

  // random-phase state
  logic [31:0] ram_mem [16];
  logic [31:0] ref_mem [16];
  logic [3:0]  i_idx, d_idx, r_idx;
  logic [31:0] d_val;
  logic        i_busy, i_fin, d_busy, d_fin, d_wr;
  int          i_age, d_age, ram_cnt, ram_lat, ndone_i, ndone_d;
  logic [31:0] exp_first, exp_second;
  logic        first_is_i;

  initial begin
    // ---------------- reset ----------------
    #1 RST = 1'b1;
    #2;
    chk1("rst.ramREN", ramREN, 1'b0);
    chk1("rst.ramWEN", ramWEN, 1'b0);
    chk32("rst.ramaddr", ramaddr, 32'h0);
    chk32("rst.ramstore", ramstore, 32'h0);
    chk1("rst.iwait", iwait, 1'b1);
    chk1("rst.dwait", dwait, 1'b1);
    chk32("rst.iload", iload, 32'h0);
    chk32("rst.dload", dload, 32'h0);
    chk1("rst.timeout", timeout, 1'b0);
    cyc(); cyc();
    RST = 1'b0;

    // ---------------- single ifetch ----------------
    cyc(); iREN = 1'b1; iaddr = 32'h40; settle();
    chk1("if.c0.ramREN", ramREN, 1'b0);
    chk1("if.c0.iwait", iwait, 1'b1);
    cyc(); ramstate = BUSY; settle();
    chk32("if.c1.ramaddr", ramaddr, 32'h40);
    chk1("if.c1.ramREN", ramREN, 1'b1);
    chk1("if.c1.iwait", iwait, 1'b1);
    cyc(); ramstate = ERR; settle();
    chk32("if.c2.ramaddr", ramaddr, 32'h40);
    chk1("if.c2.iwait", iwait, 1'b1);
    cyc(); ramstate = ACC; ramload = 32'h8C22_0004; settle();
    chk32("if.c3.ramaddr", ramaddr, 32'h40);
    chk1("if.c3.iwait", iwait, 1'b0);
    chk32("if.c3.iload", iload, 32'h8C22_0004);
    cyc(); iREN = 1'b0; ramstate = FREE; ramload = 32'h0; settle();
    chk_idle("if.c4");
    chk32("if.c4.iload", iload, 32'h0);

    // ---------------- contention ----------------
    cyc(); iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; settle();
    chk_idle("ct.c0");
    cyc(); ramstate = BUSY; settle();
    chk1("ct.c1.ramWEN", ramWEN, 1'b1);
    chk1("ct.c1.ramREN", ramREN, 1'b0);
    chk32("ct.c1.ramaddr", ramaddr, 32'h100);
    chk32("ct.c1.ramstore", ramstore, 32'hDEAD_BEEF);
    chk1("ct.c1.iwait", iwait, 1'b1);
    cyc(); ramstate = ACC; settle();
    chk1("ct.c2.dwait", dwait, 1'b0);
    chk1("ct.c2.iwait", iwait, 1'b1);
    cyc(); dWEN = 1'b0; ramstate = FREE; settle();
    chk_idle("ct.c3");
    cyc(); ramstate = BUSY; settle();
    chk1("ct.c4.ramREN", ramREN, 1'b1);
    chk32("ct.c4.ramaddr", ramaddr, 32'h80);
    chk32("ct.c4.ramstore", ramstore, 32'h0);
    cyc(); ramstate = ACC; ramload = 32'h1234_5678; settle();
    chk1("ct.c5.iwait", iwait, 1'b0);
    chk32("ct.c5.iload", iload, 32'h1234_5678);
    cyc(); iREN = 1'b0; ramstate = FREE; settle();
    chk_idle("ct.c6");

    // lone data read, then a simultaneous pair
    cyc(); dREN = 1'b1; daddr = 32'h104; settle();
    cyc(); ramstate = ACC; ramload = 32'h0000_0104; settle();
    chk1("lone.dwait", dwait, 1'b0);
    chk32("lone.dload", dload, 32'h0000_0104);
    cyc(); dREN = 1'b0; ramstate = FREE; settle();
`ifdef MEM_ARBITER_RR_EN
    first_is_i = 1'b1;
`else
    first_is_i = 1'b0;
`endif
    exp_first  = first_is_i ? 32'h84 : 32'h108;
    exp_second = first_is_i ? 32'h108 : 32'h84;
    cyc(); iREN = 1'b1; iaddr = 32'h84; dREN = 1'b1; daddr = 32'h108; settle();
    cyc(); ramstate = ACC; ramload = 32'h5555_0001; settle();
    chk32("pair.first.ramaddr", ramaddr, exp_first);
    chk1("pair.first.iwait", iwait, ~first_is_i);
    chk1("pair.first.dwait", dwait, first_is_i);
    cyc(); if (first_is_i) iREN = 1'b0; else dREN = 1'b0; ramstate = FREE; settle();
    chk_idle("pair.gap");
    cyc(); ramstate = ACC; ramload = 32'h5555_0002; settle();
    chk32("pair.second.ramaddr", ramaddr, exp_second);
    chk1("pair.second.iwait", iwait, first_is_i);
    cyc(); iREN = 1'b0; dREN = 1'b0; ramstate = FREE; settle();
    chk_idle("pair.end");

    // ---------------- lock ----------------
    cyc(); iREN = 1'b1; iaddr = 32'h44; settle();
    cyc(); ramstate = BUSY; dREN = 1'b1; daddr = 32'h200; settle();
    chk32("lock.c1.ramaddr", ramaddr, 32'h44);
    chk1("lock.c1.ramREN", ramREN, 1'b1);
    chk1("lock.c1.dwait", dwait, 1'b1);
    cyc(); ramstate = ACC; ramload = 32'hA5A5_0044; settle();
    chk32("lock.c2.ramaddr", ramaddr, 32'h44);
    chk1("lock.c2.iwait", iwait, 1'b0);
    chk1("lock.c2.dwait", dwait, 1'b1);
    cyc(); iREN = 1'b0; ramstate = FREE; settle();
    chk_idle("lock.c3");
    cyc(); ramstate = ACC; ramload = 32'h0BAD_0200; settle();
    chk32("lock.c4.ramaddr", ramaddr, 32'h200);
    chk1("lock.c4.ramREN", ramREN, 1'b1);
    chk1("lock.c4.dwait", dwait, 1'b0);
    chk32("lock.c4.dload", dload, 32'h0BAD_0200);
    cyc(); dREN = 1'b0; ramstate = FREE; settle();
    chk_idle("lock.c5");

    // ---------------- abort ----------------
    cyc(); iREN = 1'b1; iaddr = 32'h48; settle();
    cyc(); ramstate = BUSY; settle();
    chk1("abort.c1.ramREN", ramREN, 1'b1);
    cyc(); iREN = 1'b0; settle();
    chk1("abort.c2.ramREN", ramREN, 1'b0);
    chk1("abort.c2.iwait", iwait, 1'b1);
    cyc(); ramstate = ACC; ramload = 32'h7777_0048; settle();
    chk1("abort.c3.ramREN", ramREN, 1'b0);
    chk1("abort.c3.iwait", iwait, 1'b1);
    chk32("abort.c3.iload", iload, 32'h0);
    cyc(); ramstate = FREE; settle();

    // ---------------- timeout ----------------
    cyc(); dREN = 1'b1; daddr = 32'h300; settle();
    for (int k = 1; k <= TO; k++) begin
      cyc(); ramstate = BUSY; settle();
      chk1($sformatf("to.c%0d.ramREN", k), ramREN, 1'b1);
      chk1($sformatf("to.c%0d.dwait", k), dwait, 1'b1);
      chk1($sformatf("to.c%0d.timeout", k), timeout, 1'b0);
    end
    cyc(); settle();
    chk_idle("to.expired");
    chk1("to.expired.timeout", timeout, 1'b1);
    cyc(); settle();
    chk1("to.regrant.ramREN", ramREN, 1'b1);
    chk32("to.regrant.ramaddr", ramaddr, 32'h300);
    chk1("to.regrant.timeout", timeout, 1'b1);
    cyc(); dREN = 1'b0; settle();
    chk1("to.drop.ramREN", ramREN, 1'b0);
    cyc(); ramstate = FREE; settle();
    chk1("to.sticky", timeout, 1'b1);

    // ---------------- reset mid-DACC ----------------
    cyc(); dWEN = 1'b1; daddr = 32'h400; dstore = 32'hCAFE_F00D; settle();
    cyc(); ramstate = BUSY; settle();
    chk1("rd.c1.ramWEN", ramWEN, 1'b1);
    cyc(); settle();
    chk1("rd.c2.ramWEN", ramWEN, 1'b1);
    #1 RST = 1'b1;
    #1;
    chk1("rd.async.ramWEN", ramWEN, 1'b0);
    chk1("rd.async.dwait", dwait, 1'b1);
    chk32("rd.async.ramaddr", ramaddr, 32'h0);
    chk32("rd.async.ramstore", ramstore, 32'h0);
    chk1("rd.async.timeout", timeout, 1'b0);
    cyc(); dWEN = 1'b0; ramstate = FREE; settle();
    cyc(); RST = 1'b0; settle();
    chk_idle("rd.rel0");
    cyc(); settle();
    chk_idle("rd.rel1");
    chk1("rd.rel1.timeout", timeout, 1'b0);

    // ---------------- random traffic ----------------
    for (int j = 0; j < 16; j++) begin
      ram_mem[j] = $urandom;
      ref_mem[j] = ram_mem[j];
    end
    i_busy = 1'b0; i_fin = 1'b0; d_busy = 1'b0; d_fin = 1'b0; d_wr = 1'b0;
    i_idx = '0; d_idx = '0; r_idx = '0; d_val = '0;
    i_age = 0; d_age = 0; ram_cnt = 0; ram_lat = 1; ndone_i = 0; ndone_d = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (i_fin) begin iREN = 1'b0; i_busy = 1'b0; i_fin = 1'b0; end
      if (d_fin) begin dREN = 1'b0; dWEN = 1'b0; d_busy = 1'b0; d_fin = 1'b0; end
      if (!i_busy && $urandom_range(0, 99) < 45) begin
        i_busy = 1'b1; i_age = 0;
        i_idx = 4'($urandom_range(0, 15));
        iaddr = BASE + {26'h0, i_idx, 2'b00};
        iREN = 1'b1;
      end
      if (!d_busy && $urandom_range(0, 99) < 40) begin
        d_busy = 1'b1; d_age = 0;
        d_idx = 4'($urandom_range(0, 15));
        daddr = BASE + {26'h0, d_idx, 2'b00};
        d_wr = 1'($urandom_range(0, 1));
        d_val = $urandom;
        dstore = d_val;
        dWEN = d_wr;
        dREN = d_wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      end
      #1;
      // RAM model: completes an access after a random 1..3 cycles of continuous enable
      if (ramREN || ramWEN) begin
        if (ram_cnt == 0) ram_lat = $urandom_range(1, 3);
        ram_cnt++;
      end else begin
        ram_cnt = 0;
      end
      if ((ramREN || ramWEN) && ram_cnt >= ram_lat) begin
        ramstate = ACC;
        r_idx = ramaddr[5:2];
        ramload = ram_mem[r_idx];
        if (ramWEN) ram_mem[r_idx] = ramstore;
      end else begin
        ramstate = (ramREN || ramWEN) ? BUSY : FREE;
        ramload = $urandom;
      end
      #1;
      if (ramREN || ramWEN) chk1("rnd.excl_en", ramREN & ramWEN, 1'b0);
      if (!iwait || !dwait) chk1("rnd.excl_wait", ~iwait & ~dwait, 1'b0);
      if (i_busy && !iwait) begin
        chk32("rnd.iload", iload, ref_mem[i_idx]);
        i_fin = 1'b1; ndone_i++;
      end
      if (d_busy && !dwait) begin
        if (d_wr) begin
          chk1("rnd.wr.ramWEN", ramWEN, 1'b1);
          chk32("rnd.wr.ramaddr", ramaddr, BASE + {26'h0, d_idx, 2'b00});
          ref_mem[d_idx] = d_val;
        end else begin
          chk32("rnd.dload", dload, ref_mem[d_idx]);
        end
        d_fin = 1'b1; ndone_d++;
      end
      if (i_busy && !i_fin) begin
        i_age++;
        if (i_age >= 200) begin
          chk1("rnd.i_starved.iwait", iwait, 1'b0);
          iREN = 1'b0; i_busy = 1'b0;
        end
      end
      if (d_busy && !d_fin) begin
        d_age++;
        if (d_age >= 200) begin
          chk1("rnd.d_starved.dwait", dwait, 1'b0);
          dREN = 1'b0; dWEN = 1'b0; d_busy = 1'b0;
        end
      end
    end
    chk1("rnd.timeout", timeout, 1'b0);
    chk1("rnd.i_progress", ndone_i > 100, 1'b1);
    chk1("rnd.d_progress", ndone_d > 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. Consumes their iREN/iaddr and dREN/dWEN/daddr/dstore requests.
- Serialises those requests onto the single-port shared RAM and returns the wait and load signals to each cache.
- Data requests beat instruction requests by default; a granted transaction stays locked until the RAM completes it.
- Also flags RAM accesses that never complete (timeout).

Parameters:
- TIMEOUT_CYCLES, 255: max cycles one granted transaction may stay in an access state before it is abandoned.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request from icache.
- iaddr  in  32  instruction word address.
- iwait  out  1  high = instruction request not complete.
- iload  out  32  instruction read data; valid when iwait low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  high = data request not complete.
- dload  out  32  data read data; valid when dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- timeout  out  1  sticky flag: a transaction hit TIMEOUT_CYCLES.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transaction):
  - State goes to IDLE and the timeout counter clears.
  - Immediately: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
  - timeout=0 after reset.
- FSM states: IDLE, IACC, DACC. State and grant are registered.
- IDLE:
  - No RAM enables; iwait=1, dwait=1.
  - If dREN|dWEN at a clock edge -> DACC.
  - Else if iREN -> IACC.
  - Else stay in IDLE.
- DACC:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. If dREN and dWEN are both high, the write wins.
  - iwait stays 1.
  - dwait = ~(ramstate==ACCESS), combinational. dload=ramload while ramstate==ACCESS, else 0.
  - On the edge where ramstate==ACCESS, return to IDLE.
- IACC:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - dwait stays 1.
  - iwait = ~(ramstate==ACCESS); iload=ramload while ramstate==ACCESS, else 0.
  - Return to IDLE on the ACCESS edge.
  - A data request arriving during IACC waits; there is no preemption.
- Latency: request first seen in cycle 0 -> RAM driven from cycle 1 -> wait drops in the first cycle with ramstate==ACCESS. Minimum is 2 cycles.
  - Back-to-back requests take one IDLE cycle between them.
- Requester handshake: requests, addresses and store data must stay stable until the matching wait is low.
  - If the granted request drops before completion (e.g. icache abandons a miss), go to IDLE on the next edge. RAM enables follow the dropped request combinationally and go low the same cycle.
- ramstate ERROR or BUSY: keep driving, wait stays high, effectively a retry.
- Timeout counter:
  - Clears on entering IACC/DACC and increments each cycle there.
  - At TIMEOUT_CYCLES: set timeout (sticky until RST), go to IDLE. The requester's wait stays high, so it re-requests.
  - Counter saturates and never wraps.
- Nothing is ever granted while in IACC or DACC; that state is the lock.

Optional Feature:
- MEM_ARBITER_RR_EN:
  - Defined: a 1-bit last_grant register (reset = instruction) tracks the last grant. When IDLE sees both an instruction and a data request, grant the side NOT granted last. Uncontended requests are unaffected. last_grant updates on every grant.
  - Undefined: fixed priority, data over instruction, as described above.

Test Plan:
- Single ifetch: iREN=1, iaddr=0x00000040, ramstate goes ACCESS in cycle 3 with ramload=0x8C220004 -> ramaddr=0x40 in cycles 1-3; iwait=0 and iload=0x8C220004 in cycle 3 only; back in IDLE in cycle 4.
- Contention: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) raised together, RAM takes 2 cycles per access -> write granted first with ramWEN=1, ramstore=0xDEADBEEF; iwait stays high; ifetch granted after one IDLE cycle. With MEM_ARBITER_RR_EN, a second simultaneous pair grants instruction first.
- Lock: during IACC raise dREN at 0x200 -> ramaddr stays at iaddr until the ACCESS cycle; DACC begins 2 edges later.
- Abort: in IACC, drop iREN one cycle before ACCESS -> ramREN=0 the same cycle; IDLE next edge; iwait never low.
- Timeout: TIMEOUT_CYCLES=4, ramstate held BUSY -> timeout=1 after 4 access cycles, state IDLE, dwait=1; timeout stays 1 until RST.
- Reset mid-DACC: assert RST in the 2nd access cycle -> ramWEN=0 and dwait=1 without waiting for a clock edge; after release, IDLE with no enables.
